// File: rtl/ddr3_cmd_issuer.sv
// ddr3_cmd_issuer: DDR3 power-up init then spaced user command issue; ports: clk/reset, cmd_valid/cmd_ready/cmd_type/cmd_bank/cmd_addr in, init_done and registered mem_* command/address pins out
module ddr3_cmd_issuer #(
  parameter int ADDR_BITS = 13,
  parameter int BANK_BITS = 3,
  parameter int T_RESET = 200,
  parameter int T_CKE = 100,
  parameter int T_XPR = 40,
  parameter int T_MRD = 4,
  parameter int T_MOD = 12,
  parameter int T_ZQINIT = 512,
  parameter int T_RCD = 5,
  parameter int T_RP = 5,
  parameter int T_RFC = 33,
  parameter int T_CCD = 4,
  parameter int ODT_LEN = 6,
  parameter logic [ADDR_BITS-1:0] MR0_VAL = 13'h0520,
  parameter logic [ADDR_BITS-1:0] MR1_VAL = 13'h0044,
  parameter logic [ADDR_BITS-1:0] MR2_VAL = 13'h0000,
  parameter logic [ADDR_BITS-1:0] MR3_VAL = 13'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_type,
  input  logic [BANK_BITS-1:0] cmd_bank,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  output logic                 init_done,
  output logic                 mem_reset_n,
  output logic                 mem_cke,
  output logic                 mem_cs_n,
  output logic                 mem_ras_n,
  output logic                 mem_cas_n,
  output logic                 mem_we_n,
  output logic                 mem_odt,
  output logic [BANK_BITS-1:0] mem_ba,
  output logic [ADDR_BITS-1:0] mem_addr
);
  localparam int TW = 16;
  typedef enum logic [3:0] {S_RST, S_CKE, S_XPR, S_MR3, S_MR1, S_MR0, S_ZQCL, S_ZQW, S_RUN} state_t;
  state_t state;
  logic [TW-1:0] tmr, wait_cnt, odt_cnt, tmr_ld, wait_ld;
  logic tz, accept, iss_mrs, iss_zq, iss, wr;
  logic [2:0] iss_cmd;
  logic [BANK_BITS-1:0] iss_ba;
  logic [ADDR_BITS-1:0] iss_addr;
  assign cmd_ready = state == S_RUN && wait_cnt == '0;
  always_comb begin
    tz = tmr == '0;
    accept = cmd_valid && cmd_ready;
    wr = accept && cmd_type == 3'b100;
    iss_mrs = tz && (state == S_XPR || state == S_MR3 || state == S_MR1 || state == S_MR0);
    iss_zq = tz && state == S_ZQCL;
    iss = accept || iss_mrs || iss_zq;
    iss_cmd = accept ? cmd_type : iss_zq ? 3'b110 : 3'b000;
    iss_ba = accept ? cmd_bank : state == S_XPR ? BANK_BITS'(2) : state == S_MR3 ? BANK_BITS'(3) :
             state == S_MR1 ? BANK_BITS'(1) : '0;
    iss_addr = accept ? cmd_addr : iss_zq ? ADDR_BITS'(1024) : state == S_XPR ? MR2_VAL :
               state == S_MR3 ? MR3_VAL : state == S_MR1 ? MR1_VAL : MR0_VAL;
    tmr_ld = state == S_RST ? TW'(T_CKE - 1) : state == S_CKE ? TW'(T_XPR - 1) :
             state == S_MR0 ? TW'(T_MOD - 1) : state == S_ZQCL ? TW'(T_ZQINIT - 1) :
             iss_mrs ? TW'(T_MRD - 1) : '0;
    wait_ld = cmd_type == 3'b000 ? TW'(T_MRD - 1) : cmd_type == 3'b001 ? TW'(T_RFC - 1) :
              cmd_type == 3'b010 ? TW'(T_RP - 1) : cmd_type == 3'b011 ? TW'(T_RCD - 1) : TW'(T_CCD - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
      tmr <= TW'(T_RESET - 1);
      wait_cnt <= '0;
      odt_cnt <= '0;
      init_done <= 1'b0;
      mem_reset_n <= 1'b0;
      mem_cke <= 1'b0;
      mem_cs_n <= 1'b1;
      {mem_ras_n, mem_cas_n, mem_we_n} <= 3'b111;
      mem_odt <= 1'b0;
      mem_ba <= '0;
      mem_addr <= '0;
    end else begin
      if (state != S_RUN) begin
        tmr <= tz ? tmr_ld : tmr - 1'b1;
        if (tz) state <= state_t'(state + 4'd1);
      end
      mem_reset_n <= mem_reset_n || (tz && state == S_RST);
      mem_cke <= mem_cke || (tz && state == S_CKE);
      init_done <= init_done || (tz && state == S_ZQW);
      mem_cs_n <= !(iss || mem_cke || (tz && state == S_CKE));
      {mem_ras_n, mem_cas_n, mem_we_n} <= iss ? iss_cmd : 3'b111;
      if (iss) begin
        mem_ba <= iss_ba;
        mem_addr <= iss_addr;
      end
      wait_cnt <= accept ? wait_ld : wait_cnt - TW'(wait_cnt != '0);
      odt_cnt <= wr ? TW'(ODT_LEN - 1) : odt_cnt - TW'(odt_cnt != '0);
      mem_odt <= wr || odt_cnt != '0;
    end
  end
endmodule

// File: tb/tb_ddr3_cmd_issuer.sv
// tb_ddr3_cmd_issuer: scoreboard bench for ddr3_cmd_issuer init sequence, command spacing, ODT and async reset
`timescale 1ns/1ps
module tb_ddr3_cmd_issuer;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_type = 3'b111, cmd_bank = 3'd0;
  logic [12:0] cmd_addr = 13'd0;
  logic cmd_ready, init_done, mem_reset_n, mem_cke, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n, mem_odt;
  logic [2:0] mem_ba;
  logic [12:0] mem_addr;
  int cyc = 0, n_chk = 0, n_fail = 0, r0 = 0, last = 0;
  typedef struct {logic [2:0] cmd; logic [2:0] ba; logic [12:0] addr; int cyc;} bus_t;
  typedef struct {int kind; int cyc;} evt_t;
  bus_t bq[$];
  evt_t eq[$];
  bus_t mb;
  evt_t me;
  logic p_rst = 1'b0, p_cke = 1'b0, p_done = 1'b0, p_odt = 1'b0;

  ddr3_cmd_issuer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .init_done(init_done), .mem_reset_n(mem_reset_n),
    .mem_cke(mem_cke), .mem_cs_n(mem_cs_n), .mem_ras_n(mem_ras_n), .mem_cas_n(mem_cas_n),
    .mem_we_n(mem_we_n), .mem_odt(mem_odt), .mem_ba(mem_ba), .mem_addr(mem_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {mem_reset_n, mem_cke, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n, mem_odt, mem_ba, mem_addr, init_done, cmd_ready},
        {7'b0011110, 3'd0, 13'd0, 2'b00});
  endtask

  // edge kinds: 1 reset_n rise, 2 cke rise, 3 init_done rise, 4 odt rise, 5 odt fall
  task automatic evt(input int kind);
    n_chk++;
    if (eq.size() == 0) begin
      n_fail++;
      $display("FAIL edge_unexpected: kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      me = eq.pop_front();
      if (me.kind != kind || me.cyc != cyc) begin
        n_fail++;
        $display("FAIL edge: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", kind, cyc, me.kind, me.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!mem_cs_n && {mem_ras_n, mem_cas_n, mem_we_n} != 3'b111) begin
      n_chk++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL bus_unexpected: cmd=%b ba=%0d addr=%h at cycle %0d, expected none",
                 {mem_ras_n, mem_cas_n, mem_we_n}, mem_ba, mem_addr, cyc);
      end else begin
        mb = bq.pop_front();
        if ({mem_ras_n, mem_cas_n, mem_we_n, mem_ba, mem_addr} !== {mb.cmd, mb.ba, mb.addr} || cyc != mb.cyc) begin
          n_fail++;
          $display("FAIL bus_cmd: got cmd=%b ba=%0d addr=%h cyc=%0d, expected cmd=%b ba=%0d addr=%h cyc=%0d",
                   {mem_ras_n, mem_cas_n, mem_we_n}, mem_ba, mem_addr, cyc, mb.cmd, mb.ba, mb.addr, mb.cyc);
        end
      end
    end
    if (mem_reset_n && !p_rst) evt(1);
    if (mem_cke && !p_cke) evt(2);
    if (init_done && !p_done) evt(3);
    if (mem_odt !== p_odt) evt(mem_odt ? 4 : 5);
    p_rst = mem_reset_n;
    p_cke = mem_cke;
    p_done = init_done;
    p_odt = mem_odt;
  end

  task automatic exp_bus(input logic [2:0] t, input logic [2:0] b, input logic [12:0] a, input int gap);
    bus_t x;
    last += gap;
    x.cmd = t; x.ba = b; x.addr = a; x.cyc = last;
    if (t != 3'b111) bq.push_back(x);
  endtask

  task automatic exp_evt(input int k, input int c);
    evt_t x;
    x.kind = k; x.cyc = c;
    eq.push_back(x);
  endtask

  task automatic init_exp(input bit full);
    exp_evt(1, r0 + 200);
    exp_evt(2, r0 + 300);
    last = r0 + 336;
    exp_bus(3'b000, 3'd2, 13'h0000, 4);
    exp_bus(3'b000, 3'd3, 13'h0000, 4);
    exp_bus(3'b000, 3'd1, 13'h0044, 4);
    exp_bus(3'b000, 3'd0, 13'h0520, 4);
    exp_bus(3'b110, 3'd0, 13'h0400, 12);
    if (full) begin
      exp_evt(3, r0 + 876);
      last = r0 + 876;
    end
  endtask

  task automatic release_rst;
    @(negedge clk);
    reset = 1'b0;
    r0 = cyc;
  endtask

  task automatic hit_reset(input string nm);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset(nm);
    repeat (3) @(negedge clk);
  endtask

  task automatic go(input logic [2:0] t, input logic [2:0] b, input logic [12:0] a, output int w);
    cmd_valid = 1'b1; cmd_type = t; cmd_bank = b; cmd_addr = a; w = 0;
    while (!cmd_ready && w < 1500) begin
      w++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready stayed 0 for type %b, expected 1", t);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    cmd_valid = 1'b1; cmd_type = 3'b011; cmd_bank = 3'd3; cmd_addr = 13'h01A5;
    repeat (3) @(negedge clk);
    chk_reset("reset_values");
    release_rst();
    init_exp(1'b1);
    exp_bus(3'b011, 3'd3, 13'h01A5, 1); go(3'b011, 3'd3, 13'h01A5, w);
    exp_bus(3'b101, 3'd3, 13'h0010, 5); go(3'b101, 3'd3, 13'h0010, w);
    chk("rd_ready_low_cycles", 64'(w), 64'd4);
    exp_bus(3'b001, 3'd0, 13'h0000, 4); go(3'b001, 3'd0, 13'h0000, w);
    exp_bus(3'b011, 3'd1, 13'h0022, 33); go(3'b011, 3'd1, 13'h0022, w);
    exp_bus(3'b010, 3'd0, 13'h0400, 5); go(3'b010, 3'd0, 13'h0400, w);
    exp_bus(3'b011, 3'd2, 13'h0033, 5); go(3'b011, 3'd2, 13'h0033, w);
    exp_bus(3'b100, 3'd2, 13'h0008, 5);
    exp_evt(4, last);
    exp_evt(5, last + 10);
    go(3'b100, 3'd2, 13'h0008, w);
    exp_bus(3'b100, 3'd2, 13'h0010, 4); go(3'b100, 3'd2, 13'h0010, w);
    exp_bus(3'b111, 3'd0, 13'h0000, 4); go(3'b111, 3'd0, 13'h0000, w);
    exp_bus(3'b110, 3'd0, 13'h0000, 4); go(3'b110, 3'd0, 13'h0000, w);
    exp_bus(3'b000, 3'd1, 13'h0044, 4); go(3'b000, 3'd1, 13'h0044, w);
    exp_bus(3'b101, 3'd0, 13'h0400, 4); go(3'b101, 3'd0, 13'h0400, w);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("main_bus_pending", 64'(bq.size()), 64'd0);
    chk("main_edge_pending", 64'(eq.size()), 64'd0);
    hit_reset("reset_after_run");
    release_rst();
    init_exp(1'b0);
    repeat (600) @(negedge clk);
    chk("zq_wait_bus_pending", 64'(bq.size()), 64'd0);
    hit_reset("reset_in_zq_wait");
    release_rst();
    init_exp(1'b1);
    exp_bus(3'b011, 3'd5, 13'h0ABC, 1); go(3'b011, 3'd5, 13'h0ABC, w);
    cmd_type = 3'b101; cmd_bank = 3'd5; cmd_addr = 13'h0010;
    hit_reset("reset_in_act_rd_gap");
    release_rst();
    init_exp(1'b1);
    exp_bus(3'b101, 3'd5, 13'h0010, 1); go(3'b101, 3'd5, 13'h0010, w);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("final_bus_pending", 64'(bq.size()), 64'd0);
    chk("final_edge_pending", 64'(eq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
